// File: rtl/ip_stride_pkg.sv
// Shared types and helpers for the IP-indexed stride prefetcher.
// Data-path widths are fixed here; table geometry is a top-level parameter.
package ip_stride_pkg;

    localparam int ADDR_W       = 64;
    localparam int IP_W         = 64;
    localparam int LOG2_BLOCK   = 6;
    localparam int CLA_W        = ADDR_W - LOG2_BLOCK;
    localparam int CONF_W       = 2;
    localparam int DEG_W        = 4;
    localparam int MAX_TRACKERS = 64;

    typedef logic [ADDR_W-1:0]                 addr_t;
    typedef logic [IP_W-1:0]                   ip_t;
    typedef logic [CLA_W-1:0]                  cla_t;
    typedef logic signed [CLA_W-1:0]           stride_t;
    typedef logic [CONF_W-1:0]                 conf_t;
    typedef logic [$clog2(MAX_TRACKERS)-1:0]   age_t;
    typedef logic [DEG_W-1:0]                  deg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_ISSUE
    } pf_state_e;

    typedef struct packed {
        logic    valid;
        ip_t     ip;
        cla_t    last_cla;
        stride_t last_stride;
        conf_t   conf;
    } tracker_t;

    function automatic deg_t clamp_degree(deg_t d, int max_d);
        return (int'(d) > max_d) ? deg_t'(max_d) : d;
    endfunction

    function automatic logic same_page(cla_t a, cla_t b, int page_shift);
        return (a >> page_shift) == (b >> page_shift);
    endfunction

endpackage

// File: rtl/pf_lru_ages.sv
// Age table for the tracker array: touched entry becomes age 0, younger entries age by one.
// Ages always form a permutation of 0..TRACKERS-1, so the oldest entry is unique.
module pf_lru_ages
    import ip_stride_pkg::*;
#(
    parameter int TRACKERS = 64,
    parameter int IDX_W    = $clog2(TRACKERS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [IDX_W-1:0] victim_o
);

    age_t age_q [TRACKERS];
    age_t age_d [TRACKERS];
    age_t max_age;

    always_comb begin
        // NOTE: every always_comb target gets a default before any branch, so no latch can be inferred.
        for (int i = 0; i < TRACKERS; i++) begin
            age_d[i] = age_q[i];
            if (touch_i) begin
                if (i == int'(idx_i)) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[idx_i]) begin
                    age_d[i] = age_q[i] + age_t'(1);
                end
            end
        end
    end

    always_comb begin
        victim_o = '0;
        max_age  = age_q[0];
        for (int i = 1; i < TRACKERS; i++) begin
            if (age_q[i] > max_age) begin
                max_age  = age_q[i];
                victim_o = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: this small table is reset (unlike a data RAM) because the victim logic relies on a valid permutation.
        // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
        if (rst) begin
            for (int i = 0; i < TRACKERS; i++) begin
                age_q[i] <= age_t'(i);
            end
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/ip_stride_conf_pf.sv
// IP-indexed stride prefetcher with confidence hysteresis, runtime degree,
// valid/ready prefetch port and clipping of candidates to the trigger page.
module ip_stride_conf_pf
    import ip_stride_pkg::*;
#(
    parameter int TRACKERS    = 64,
    parameter int LOG2_PAGE   = 12,
    parameter int MAX_DEGREE  = 3,
    parameter int CONF_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_valid_i,
    output logic              acc_ready_o,
    input  logic [ADDR_W-1:0] acc_addr_i,
    input  logic [IP_W-1:0]   acc_ip_i,
    input  logic [3:0]        degree_i,
    output logic              pf_valid_o,
    input  logic              pf_ready_i,
    output logic [ADDR_W-1:0] pf_addr_o
);

    localparam int IDX_W      = $clog2(TRACKERS);
    localparam int PAGE_SHIFT = LOG2_PAGE - LOG2_BLOCK;

    pf_state_e state_q, state_d;
    ip_t       ip_q, ip_d;
    cla_t      cla_q, cla_d;
    deg_t      deg_q, deg_d;
    stride_t   stride_q, stride_d;
    deg_t      k_q, k_d;
    cla_t      cand_q, cand_d;
    logic      pf_valid_q, pf_valid_d;
    addr_t     pf_addr_q, pf_addr_d;
    tracker_t  trk_q [TRACKERS];
    tracker_t  trk_d [TRACKERS];

    logic             hit, inv_found, touch;
    logic [IDX_W-1:0] hit_idx, inv_idx, victim_idx, touch_idx;
    tracker_t         hit_trk, upd;
    stride_t          stride;
    cla_t             first_cla, next_cla;

    // Byte offset within a line carries no training information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^acc_addr_i[LOG2_BLOCK-1:0];

    pf_lru_ages #(.TRACKERS(TRACKERS)) u_ages (
        .clk      (clk),
        .rst      (rst),
        .touch_i  (touch),
        .idx_i    (touch_idx),
        .victim_o (victim_idx)
    );

    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = 0; i < TRACKERS; i++) begin
            if (trk_q[i].valid && trk_q[i].ip == ip_q) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        for (int i = TRACKERS - 1; i >= 0; i--) begin
            if (!trk_q[i].valid) begin
                inv_found = 1'b1;
                inv_idx   = IDX_W'(i);
            end
        end
    end

    assign hit_trk     = trk_q[hit_idx];
    assign stride      = stride_t'(cla_q - hit_trk.last_cla);
    assign first_cla   = cla_q + cla_t'(stride);
    assign next_cla    = cand_q + cla_t'(stride_q);
    assign acc_ready_o = (state_q == ST_IDLE);
    assign pf_valid_o  = pf_valid_q;
    assign pf_addr_o   = pf_addr_q;

    always_comb begin
        state_d    = state_q;
        ip_d       = ip_q;
        cla_d      = cla_q;
        deg_d      = deg_q;
        stride_d   = stride_q;
        k_d        = k_q;
        cand_d     = cand_q;
        pf_valid_d = pf_valid_q;
        pf_addr_d  = pf_addr_q;
        trk_d      = trk_q;
        touch      = 1'b0;
        touch_idx  = hit_idx;
        upd        = hit_trk;

        case (state_q)
            ST_IDLE: begin
                if (acc_valid_i) begin
                    ip_d    = acc_ip_i;
                    cla_d   = cla_t'(acc_addr_i >> LOG2_BLOCK);
                    deg_d   = clamp_degree(degree_i, MAX_DEGREE);
                    state_d = ST_UPDATE;
                end
            end

            ST_UPDATE: begin
                state_d = ST_IDLE;
                touch   = 1'b1;
                if (!hit) begin
                    touch_idx        = inv_found ? inv_idx : victim_idx;
                    trk_d[touch_idx] = '{valid: 1'b1, ip: ip_q, last_cla: cla_q,
                                         last_stride: '0, conf: '0};
                end else if (stride != '0) begin
                    upd.last_cla = cla_q;
                    if (stride == hit_trk.last_stride) begin
                        if (hit_trk.conf != '1) upd.conf = hit_trk.conf + conf_t'(1);
                    end else if (hit_trk.conf == '0) begin
                        upd.last_stride = stride;
                    end else begin
                        upd.conf = hit_trk.conf - conf_t'(1);
                    end
                    trk_d[hit_idx] = upd;
                    // A first candidate outside the page ends the burst before it starts.
                    if (stride == hit_trk.last_stride && upd.conf >= conf_t'(CONF_THRESH) &&
                        deg_q != '0 && same_page(first_cla, cla_q, PAGE_SHIFT)) begin
                        stride_d   = stride;
                        k_d        = deg_t'(1);
                        cand_d     = first_cla;
                        pf_valid_d = 1'b1;
                        pf_addr_d  = {first_cla, {LOG2_BLOCK{1'b0}}};
                        state_d    = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (pf_ready_i) begin
                    if (k_q >= deg_q || !same_page(next_cla, cla_q, PAGE_SHIFT)) begin
                        pf_valid_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        k_d       = k_q + deg_t'(1);
                        cand_d    = next_cla;
                        pf_addr_d = {next_cla, {LOG2_BLOCK{1'b0}}};
                    end
                end
            end

            default: begin
                pf_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ip_q       <= '0;
            cla_q      <= '0;
            deg_q      <= '0;
            stride_q   <= '0;
            k_q        <= '0;
            cand_q     <= '0;
            pf_valid_q <= 1'b0;
            pf_addr_q  <= '0;
            for (int i = 0; i < TRACKERS; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ip_q       <= ip_d;
            cla_q      <= cla_d;
            deg_q      <= deg_d;
            stride_q   <= stride_d;
            k_q        <= k_d;
            cand_q     <= cand_d;
            pf_valid_q <= pf_valid_d;
            pf_addr_q  <= pf_addr_d;
            trk_q      <= trk_d;
        end
    end

endmodule

// File: tb/tb_ip_stride_conf_pf.sv
// Bench for ip_stride_conf_pf: table-driven access vectors with an expected-prefetch queue,
// plus hand sequences for LRU eviction (4-entry instance) and reset during a burst.
module tb_ip_stride_conf_pf;

    logic        clk;
    logic        rst;
    logic        acc_valid_i;
    logic [63:0] acc_addr_i;
    logic [63:0] acc_ip_i;
    logic [3:0]  degree_i;
    logic        pf_ready_i;

    logic        acc_ready_o, pf_valid_o;
    logic [63:0] pf_addr_o;
    logic        s_acc_ready, s_pf_valid;
    logic [63:0] s_pf_addr;

    bit          sel;
    logic        mon_acc_ready, mon_pf_valid;
    logic [63:0] mon_pf_addr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q [$];

    typedef struct {
        logic [63:0] ip;
        logic [63:0] addr;
        logic [3:0]  deg;
        int          stall;
        int          n;
        logic [63:0] pf [3];
    } vec_t;

    vec_t vecs [$];

    ip_stride_conf_pf dut (
        .clk         (clk),
        .rst         (rst),
        .acc_valid_i (acc_valid_i),
        .acc_ready_o (acc_ready_o),
        .acc_addr_i  (acc_addr_i),
        .acc_ip_i    (acc_ip_i),
        .degree_i    (degree_i),
        .pf_valid_o  (pf_valid_o),
        .pf_ready_i  (pf_ready_i),
        .pf_addr_o   (pf_addr_o)
    );

    ip_stride_conf_pf #(.TRACKERS(4)) dut_small (
        .clk         (clk),
        .rst         (rst),
        .acc_valid_i (acc_valid_i),
        .acc_ready_o (s_acc_ready),
        .acc_addr_i  (acc_addr_i),
        .acc_ip_i    (acc_ip_i),
        .degree_i    (degree_i),
        .pf_valid_o  (s_pf_valid),
        .pf_ready_i  (pf_ready_i),
        .pf_addr_o   (s_pf_addr)
    );

    assign mon_acc_ready = sel ? s_acc_ready : acc_ready_o;
    assign mon_pf_valid  = sel ? s_pf_valid  : pf_valid_o;
    assign mon_pf_addr   = sel ? s_pf_addr   : pf_addr_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [63:0] ip, input logic [63:0] addr, input logic [3:0] deg,
                           input int stall, input int n,
                           input logic [63:0] p0, input logic [63:0] p1, input logic [63:0] p2);
        vec_t v;
        v.ip = ip; v.addr = addr; v.deg = deg; v.stall = stall; v.n = n;
        v.pf[0] = p0; v.pf[1] = p1; v.pf[2] = p2;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one access and follows it until the selected DUT returns to IDLE.
    task automatic do_access(input logic [63:0] ip, input logic [63:0] addr,
                             input logic [3:0] deg, input int stall);
        int guard, cyc, first, stall_left, n_exp, n_seen;
        guard = 0;
        while (!mon_acc_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("acc_ready_before_access", mon_acc_ready, 1'b1);
        n_exp      = exp_q.size();
        n_seen     = 0;
        stall_left = stall;
        first      = -1;
        acc_valid_i = 1'b1;
        acc_ip_i    = ip;
        acc_addr_i  = addr;
        degree_i    = deg;
        @(negedge clk);
        acc_valid_i = 1'b0;
        cyc = 1;
        check("acc_ready_low_in_update", mon_acc_ready, 1'b0);
        while (cyc < 64) begin
            pf_ready_i = (stall_left == 0);
            if (mon_pf_valid) begin
                if (first < 0) first = cyc;
                if (!pf_ready_i) stall_left--;
                check("acc_ready_low_in_issue", mon_acc_ready, 1'b0);
                if (exp_q.size() != 0) check("pf_addr", mon_pf_addr, exp_q[0]);
                if (pf_ready_i) begin
                    n_seen++;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                end
            end else if (mon_acc_ready) begin
                break;
            end
            @(negedge clk);
            cyc++;
        end
        pf_ready_i = 1'b1;
        check("burst_ends_in_budget", 64'(cyc < 64), 1'b1);
        check("pf_count", 64'(n_seen), 64'(n_exp));
        if (n_exp > 0) check("first_pf_latency", 64'(first), 64'd2);
        exp_q.delete();
    endtask

    initial begin
        rst         = 1'b1;
        acc_valid_i = 1'b0;
        acc_addr_i  = '0;
        acc_ip_i    = '0;
        degree_i    = 4'd3;
        pf_ready_i  = 1'b1;
        sel         = 1'b0;

        // ip, addr, degree, stall cycles, prefetch count, expected prefetch addresses
        add_vec(64'h000, 64'h0000, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'h400, 64'h1000, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'h400, 64'h1040, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'h400, 64'h1080, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'h400, 64'h10C0, 4'd3, 0, 3, 64'h1100, 64'h1140, 64'h1180);
        add_vec(64'h500, 64'h2200, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'h500, 64'h2180, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'h500, 64'h2100, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'h500, 64'h2080, 4'd3, 0, 1, 64'h2000, 0, 0);
        add_vec(64'h600, 64'h1000, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'h600, 64'h1040, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'h600, 64'h1080, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'h600, 64'h10C0, 4'd3, 5, 3, 64'h1100, 64'h1140, 64'h1180);
        add_vec(64'h700, 64'h3000, 4'd1, 0, 0, 0, 0, 0);
        add_vec(64'h700, 64'h3040, 4'd1, 0, 0, 0, 0, 0);
        add_vec(64'h700, 64'h3080, 4'd1, 0, 0, 0, 0, 0);
        add_vec(64'h700, 64'h30C0, 4'd1, 0, 1, 64'h3100, 0, 0);
        add_vec(64'h800, 64'h4000, 4'd0, 0, 0, 0, 0, 0);
        add_vec(64'h800, 64'h4040, 4'd0, 0, 0, 0, 0, 0);
        add_vec(64'h800, 64'h4080, 4'd0, 0, 0, 0, 0, 0);
        add_vec(64'h800, 64'h40C0, 4'd0, 0, 0, 0, 0, 0);
        add_vec(64'h800, 64'h4100, 4'd3, 0, 3, 64'h4140, 64'h4180, 64'h41C0);
        add_vec(64'h900, 64'h7000, 4'd15, 0, 0, 0, 0, 0);
        add_vec(64'h900, 64'h7040, 4'd15, 0, 0, 0, 0, 0);
        add_vec(64'h900, 64'h7080, 4'd15, 0, 0, 0, 0, 0);
        add_vec(64'h900, 64'h70C0, 4'd15, 0, 3, 64'h7100, 64'h7140, 64'h7180);
        add_vec(64'hB00, 64'h8E80, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'hB00, 64'h8EC0, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'hB00, 64'h8F00, 4'd3, 0, 0, 0, 0, 0);
        add_vec(64'hB00, 64'h8F40, 4'd3, 0, 2, 64'h8F80, 64'h8FC0, 0);

        @(negedge clk);
        do_reset();
        check("reset_pf_valid", pf_valid_o, 1'b0);
        check("reset_pf_addr", pf_addr_o, 64'h0);
        check("reset_acc_ready", acc_ready_o, 1'b1);
        check("reset_small_pf_valid", s_pf_valid, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int j = 0; j < vecs[i].n; j++) exp_q.push_back(vecs[i].pf[j]);
            do_access(vecs[i].ip, vecs[i].addr, vecs[i].deg, vecs[i].stall);
        end

        // Reset in the middle of a stalled burst.
        do_access(64'hA00, 64'h9000, 4'd3, 0);
        do_access(64'hA00, 64'h9040, 4'd3, 0);
        do_access(64'hA00, 64'h9080, 4'd3, 0);
        acc_valid_i = 1'b1;
        acc_ip_i    = 64'hA00;
        acc_addr_i  = 64'h90C0;
        degree_i    = 4'd3;
        pf_ready_i  = 1'b0;
        @(negedge clk);
        acc_valid_i = 1'b0;
        @(negedge clk);
        check("stalled_pf_valid", pf_valid_o, 1'b1);
        check("stalled_pf_addr", pf_addr_o, 64'h9100);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_issue_pf_valid", pf_valid_o, 1'b0);
        check("rst_mid_issue_pf_addr", pf_addr_o, 64'h0);
        check("rst_mid_issue_acc_ready", acc_ready_o, 1'b1);
        rst        = 1'b0;
        pf_ready_i = 1'b1;
        do_access(64'hA00, 64'h9100, 4'd3, 0);

        // Four-entry instance: a trained IP is evicted by four newer IPs and restarts cold.
        do_reset();
        sel = 1'b1;
        do_access(64'hC00, 64'h5000, 4'd3, 0);
        do_access(64'hC00, 64'h5040, 4'd3, 0);
        do_access(64'hC00, 64'h5080, 4'd3, 0);
        exp_q.push_back(64'h5100);
        exp_q.push_back(64'h5140);
        exp_q.push_back(64'h5180);
        do_access(64'hC00, 64'h50C0, 4'd3, 0);
        for (int i = 0; i < 4; i++) begin
            do_access(64'hD00 + 64'(i) * 64'h100, 64'h6000, 4'd3, 0);
        end
        do_access(64'hC00, 64'h5100, 4'd3, 0);
        do_access(64'hC00, 64'h5140, 4'd3, 0);
        sel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
